// File: rtl/interrupt_controller.sv
// Four-source edge-triggered interrupt controller with PEND/MASK/CAUSE bus registers.
// irq is registered; rdata is combinational; no backpressure (single-cycle bus access).
module interrupt_controller #(
  parameter logic [31:0] BASE = 32'h4000_0030
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_src,
  input  logic        pc31,
  input  logic        entry,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [1:0]  cause_id
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  localparam logic [31:0] A_MASK  = BASE + 32'd4;
  localparam logic [31:0] A_CAUSE = BASE + 32'd8;

  state_t      r_state, w_next;
  logic [3:0]  r_src_q, r_pend, r_mask;
  logic        r_pc31_q, r_armed, r_irq;
  logic [1:0]  r_cause;

  logic        w_sel_pend, w_sel_mask, w_sel_cause;
  logic [3:0]  w_rise, w_act, w_w1c, w_clr_entry;
  logic [1:0]  w_gid;
  logic        w_take;

  assign w_sel_pend  = (addr[31:2] == BASE[31:2]);
  assign w_sel_mask  = (addr[31:2] == A_MASK[31:2]);
  assign w_sel_cause = (addr[31:2] == A_CAUSE[31:2]);

  // r_armed masks the first cycle after reset so a source already high is absorbed into src_q.
  assign w_rise = irq_src & ~r_src_q & {4{r_armed}};
  assign w_act  = r_pend & r_mask;
  assign w_w1c  = (wr && w_sel_pend) ? wdata[3:0] : 4'b0;

  always_comb begin
    w_gid = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_act[i]) w_gid = 2'(i);
    end
  end

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      S_IDLE:    if (w_act != 4'b0 && !pc31) w_next = S_REQ;
      S_REQ: begin
        if (w_act == 4'b0) begin
          w_next = S_IDLE;
        end else if (entry) begin
          w_next = S_SERVICE;
          w_take = 1'b1;
        end
      end
      S_SERVICE: if (r_pc31_q && !pc31) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  assign w_clr_entry = w_take ? (4'b0001 << w_gid) : 4'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_src_q  <= 4'b0;
      r_pend   <= 4'b0;
      r_mask   <= 4'b0;
      r_pc31_q <= 1'b0;
      r_armed  <= 1'b0;
      r_irq    <= 1'b0;
      r_cause  <= 2'd0;
    end else begin
      r_state  <= w_next;
      r_src_q  <= irq_src;
      r_pc31_q <= pc31;
      r_armed  <= 1'b1;
      r_irq    <= (w_next == S_REQ);
      // Set has priority over both write-1-to-clear and the entry clear.
      r_pend   <= (r_pend & ~(w_w1c | w_clr_entry)) | w_rise;
      if (wr && w_sel_mask) r_mask <= wdata[3:0];
      if (w_take) r_cause <= w_gid;
    end
  end

  always_comb begin
    rdata = 32'b0;
    if (rd) begin
      if (w_sel_pend)       rdata = {28'b0, r_pend};
      else if (w_sel_mask)  rdata = {28'b0, r_mask};
      else if (w_sel_cause) rdata = {27'b0, (r_state == S_SERVICE), 2'b0, r_cause};
    end
  end

  assign irq      = r_irq;
  assign cause_id = r_cause;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;

  localparam logic [31:0] BASE = 32'h4000_0030;
  localparam logic [31:0] A_PEND  = BASE;
  localparam logic [31:0] A_MASK  = BASE + 32'd4;
  localparam logic [31:0] A_CAUSE = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_src = 4'b0;
  logic        pc31 = 1'b0;
  logic        entry = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'b0;
  logic [31:0] wdata = 32'b0;
  logic [31:0] rdata;
  logic        irq;
  logic [1:0]  cause_id;

  int total = 0;
  int bad = 0;

  interrupt_controller #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .pc31(pc31), .entry(entry),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
    .irq(irq), .cause_id(cause_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    tick();
    wr = 1'b0; addr = 32'b0; wdata = 32'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    rd = 1'b1; addr = a;
    #1;
    v = rdata;
    rd = 1'b0; addr = 32'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    irq_src = 4'b0001;
    repeat (3) tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (cause_id !== 2'd0) begin bad++; $display("FAIL reset_cause_id: got %0d want 0", cause_id); end
    bus_read(A_MASK, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_mask: got %h want 0", v); end
    reset = 1'b1;
    repeat (3) tick();
    bus_read(A_PEND, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_src_high_no_pend: got %h want 0", v); end
    irq_src = 4'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] v;
    bus_write(A_MASK, 32'hF);
    irq_src = 4'b0010;
    tick();
    irq_src = 4'b0;
    bus_read(A_PEND, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL basic_pend: got %h want 2", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_early: got %b want 0", irq); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq: got %b want 1", irq); end
    entry = 1'b1; tick(); entry = 1'b0;
    total++; if (cause_id !== 2'd1) begin bad++; $display("FAIL basic_cause_id: got %0d want 1", cause_id); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_entry: got %b want 0", irq); end
    bus_read(A_PEND, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL basic_pend_clr: got %h want 0", v); end
    bus_read(A_CAUSE, v);
    total++; if (v !== 32'h11) begin bad++; $display("FAIL basic_cause_reg: got %h want 11", v); end
    pc31 = 1'b1; tick();
    pc31 = 1'b0; tick();
    bus_read(A_CAUSE, v);
    total++; if (v !== 32'h01) begin bad++; $display("FAIL basic_exit_service: got %h want 01", v); end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    irq_src = 4'b1001; tick();
    irq_src = 4'b0;    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL prio_irq: got %b want 1", irq); end
    entry = 1'b1; tick(); entry = 1'b0;
    total++; if (cause_id !== 2'd0) begin bad++; $display("FAIL prio_grant0: got %0d want 0", cause_id); end
    bus_read(A_PEND, v);
    total++; if (v !== 32'h8) begin bad++; $display("FAIL prio_pend_left: got %h want 8", v); end
    pc31 = 1'b1; tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL prio_service_irq: got %b want 0", irq); end
    pc31 = 1'b0; tick();
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL prio_reassert: got %b want 1", irq); end
    entry = 1'b1; tick(); entry = 1'b0;
    total++; if (cause_id !== 2'd3) begin bad++; $display("FAIL prio_grant3: got %0d want 3", cause_id); end
    pc31 = 1'b1; tick();
    pc31 = 1'b0; tick();
  endtask

  task automatic test_mask();
    logic [31:0] v;
    bus_write(A_MASK, 32'h0);
    irq_src = 4'b0100; tick();
    irq_src = 4'b0;    tick();
    bus_read(A_PEND, v);
    total++; if (v !== 32'h4) begin bad++; $display("FAIL mask_pend: got %h want 4", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_off: got %b want 0", irq); end
    bus_write(A_MASK, 32'h4);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_1cyc: got %b want 0", irq); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq_2cyc: got %b want 1", irq); end
  endtask

  task automatic test_w1c();
    logic [31:0] v;
    bus_write(A_PEND, 32'hF);
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_req_drop: got %b want 0", irq); end
    bus_read(A_CAUSE, v);
    total++; if (v !== 32'h03) begin bad++; $display("FAIL w1c_state_idle: got %h want 03", v); end
    bus_write(A_MASK, 32'h0);
    irq_src = 4'b0010;
    bus_write(A_PEND, 32'h2);
    irq_src = 4'b0;
    bus_read(A_PEND, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL w1c_set_wins: got %h want 2", v); end
    bus_write(A_PEND, 32'h2);
    bus_read(A_PEND, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL w1c_clear: got %h want 0", v); end
    bus_write(A_CAUSE, 32'hF);
    bus_write(BASE + 32'd12, 32'hF);
    bus_write(BASE - 32'd4, 32'hF);
    bus_read(A_CAUSE, v);
    total++; if (v !== 32'h03) begin bad++; $display("FAIL cause_write_ignored: got %h want 03", v); end
    bus_read(A_MASK, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL unmatched_write: got %h want 0", v); end
    bus_write(BASE + 32'd5, 32'hFFFF_FFF3);
    bus_read(BASE + 32'd6, v);
    total++; if (v !== 32'h3) begin bad++; $display("FAIL mask_low_addr_bits: got %h want 3", v); end
    addr = A_MASK; rd = 1'b0; #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rdata_no_rd: got %h want 0", rdata); end
    addr = 32'b0;
  endtask

  task automatic test_kernel();
    logic [31:0] v;
    bus_write(A_MASK, 32'hF);
    pc31 = 1'b1;
    irq_src = 4'b0001; tick();
    irq_src = 4'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL kernel_hold_irq[%0d]: got %b want 0", i, irq); end
    end
    entry = 1'b1; tick(); entry = 1'b0;
    bus_read(A_PEND, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL idle_entry_pend: got %h want 1", v); end
    bus_read(A_CAUSE, v);
    total++; if (v !== 32'h03) begin bad++; $display("FAIL idle_entry_cause: got %h want 03", v); end
    pc31 = 1'b0; tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL kernel_release_irq: got %b want 1", irq); end
    entry = 1'b1; tick(); entry = 1'b0;
    pc31 = 1'b1;
    irq_src = 4'b0100; tick();
    irq_src = 4'b0;    tick();
    bus_read(A_PEND, v);
    total++; if (v !== 32'h4) begin bad++; $display("FAIL service_accumulate: got %h want 4", v); end
    bus_read(A_CAUSE, v);
    total++; if (v !== 32'h10) begin bad++; $display("FAIL service_cause: got %h want 10", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL service_irq: got %b want 0", irq); end
    reset = 1'b0; #1;
    total++; if (irq !== 1'b0 || cause_id !== 2'd0) begin bad++; $display("FAIL midreset_out: got irq=%b cause=%0d want 0/0", irq, cause_id); end
    bus_read(A_PEND, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL midreset_pend: got %h want 0", v); end
    bus_read(A_MASK, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL midreset_mask: got %h want 0", v); end
    bus_read(A_CAUSE, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL midreset_cause: got %h want 0", v); end
    tick();
    reset = 1'b1;
    pc31 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_w1c();
    test_kernel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
